spi_frame_master: RTL

Streams one display frame of 16-bit RGB565 words from the host-side pixel source into the panel controller's SPI slave. Drives spi_cs, spi_sclk and spi_mosi using the slave's protocol. The slave's word index is implicit and counts from 0 while cs is high; bit 10 of that index selects the upper half-panel bank. This block therefore sends exactly FRAME_WORDS words per cs window, in address order. It sits between a pixel FIFO/generator (ready/valid) and the board pins.

---
 rtl/ledz_pkg.sv | 27 ++
 rtl/spi_sclk_gen.sv | 43 ++++
 rtl/spi_frame_master.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ledz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ledz_pkg: shared constants and SPI transmit state encoding.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ledz_pkg;

  localparam int RGB565_W     = 16;
  localparam int PANEL_WORDS  = 2048;
  localparam int BANK_SEL_BIT = 10;
  localparam int BIT_CNT_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_TAIL  = 3'd4,
    ST_GAP   = 3'd5
  } spi_tx_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sclk_gen: sclk divider with rise/fall strobes, runs only when    |
// | enabled. Rev 1.0                                                     |
// +----------------------------------------------------------------------+
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sclk;
  logic             w_tc;

  // Strobes flag the cycle whose closing edge toggles sclk.
  assign w_tc   = i_en && (r_div == c_DIV_LAST);
  assign o_rise = w_tc && !r_sclk;
  assign o_fall = w_tc && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_frame_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_frame_master: streams one frame of RGB565 words to the panel     |
// | SPI slave inside a single cs window. Rev 1.0                         |
// +----------------------------------------------------------------------+
module spi_frame_master
  import ledz_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_WORDS = PANEL_WORDS,
  parameter int CS_GAP      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [RGB565_W-1:0] word_data,
  input  logic                word_valid,
  output logic                word_ready,
  output logic                spi_cs,
  output logic                spi_sclk,
  output logic                spi_mosi,
  output logic                busy,
  output logic                frame_done
);

  localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int WAIT_W = $clog2(max2(CLK_DIV, CS_GAP) + 1);
  localparam logic [CNT_W-1:0]  c_FRAME_WORDS = CNT_W'(FRAME_WORDS);
  localparam logic [WAIT_W-1:0] c_EDGE_LAST   = WAIT_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] c_GAP_DONE    = WAIT_W'(CS_GAP - 1);
  localparam logic [WAIT_W-1:0] c_GAP_LAST    = WAIT_W'(CS_GAP);

  spi_tx_state_t           r_state;
  spi_tx_state_t           w_state_nxt;
  logic [CNT_W-1:0]        r_words;
  logic [CNT_W-1:0]        w_words_inc;
  logic [BIT_CNT_W-1:0]    r_bit;
  logic                    r_last_bit;
  logic [RGB565_W-1:0]     r_shift;
  logic [WAIT_W-1:0]       r_wait;
  logic                    r_cs;
  logic                    r_mosi;
  logic                    r_busy;
  logic                    r_done;
  logic                    w_accept;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_word_end;
  logic                    w_sclk_en;
  logic                    w_cs_nxt;
  logic                    w_done_nxt;
  logic                    w_wait_clr;

  assign word_ready  = (r_state == ST_FETCH);
  assign w_accept    = word_ready && word_valid;
  assign w_word_end  = w_fall && r_last_bit;
  assign w_words_inc = r_words + 1'b1;
  assign w_sclk_en   = (r_state == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_sclk_en),
    .o_sclk (spi_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_LEAD;
      ST_LEAD:  if (r_wait == c_EDGE_LAST) w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_word_end)
          w_state_nxt = (w_words_inc == c_FRAME_WORDS) ? ST_TAIL : ST_FETCH;
      end
      ST_TAIL:  if (r_wait == c_EDGE_LAST) w_state_nxt = ST_GAP;
      ST_GAP: begin
        // frame_done occupies the final GAP cycle so a coincident start still lands in GAP.
        if (r_wait == c_GAP_DONE) w_done_nxt = 1'b1;
        if (r_wait == c_GAP_LAST) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
    w_cs_nxt   = (w_state_nxt == ST_LEAD)  || (w_state_nxt == ST_FETCH) ||
                 (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_TAIL);
    w_wait_clr = (w_state_nxt != r_state) || (r_state == ST_IDLE) ||
                 (r_state == ST_FETCH) || (r_state == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait     <= '0;
      r_words    <= '0;
      r_bit      <= '0;
      r_last_bit <= 1'b0;
      r_shift    <= '0;
      r_cs       <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cs    <= w_cs_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      r_wait  <= w_wait_clr ? '0 : r_wait + 1'b1;

      if ((r_state == ST_IDLE) && start)
        r_words <= '0;
      else if (w_word_end)
        r_words <= w_words_inc;

      // Shifter refills with zeros, so mosi returns low after the 16th fall.
      if (w_accept) begin
        r_shift    <= {word_data[RGB565_W-2:0], 1'b0};
        r_mosi     <= word_data[RGB565_W-1];
        r_bit      <= '0;
        r_last_bit <= 1'b0;
      end else if (w_rise) begin
        if (r_bit == 4'd15) r_last_bit <= 1'b1;
        else                r_bit      <= r_bit + 1'b1;
      end else if (w_fall) begin
        r_mosi  <= r_shift[RGB565_W-1];
        r_shift <= {r_shift[RGB565_W-2:0], 1'b0};
      end
    end
  end

  assign spi_cs     = r_cs;
  assign spi_mosi   = r_mosi;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule
`default_nettype wire
